// File: rtl/rv32x_wrapper_if.sv
// ---------------------------------------------------------------------------
// rv32x_wrapper_if
//   Internal core <-> memory bus of the rv32x system.
//   master (core side):
//     imem_idx   out  ICCM word index (pc[IAW+1:2])
//     imem_rdata in   fetched instruction word (combinational)
//     dmem_waddr out  data word address (effective byte address [31:2])
//     dmem_be    out  byte-lane write strobes, all zero when not storing
//     dmem_wdata out  store data, already replicated onto the active lanes
//     dmem_rdata in   load word, zero when the address misses the DCCM
//   slave (memory side): the same signals with the directions reversed.
// ---------------------------------------------------------------------------
interface rv32x_wrapper_if #(
  parameter int IAW = 10
);
  logic [IAW-1:0] imem_idx;
  logic [31:0]    imem_rdata;
  logic [29:0]    dmem_waddr;
  logic [3:0]     dmem_be;
  logic [31:0]    dmem_wdata;
  logic [31:0]    dmem_rdata;

  modport master (
    output imem_idx, dmem_waddr, dmem_be, dmem_wdata,
    input  imem_rdata, dmem_rdata
  );

  modport slave (
    input  imem_idx, dmem_waddr, dmem_be, dmem_wdata,
    output imem_rdata, dmem_rdata
  );
endinterface

// File: rtl/rv32x_wrapper.sv
// ---------------------------------------------------------------------------
// rv32x_wrapper
//   Self-contained RV32I system: single-cycle RV32I core (core_i) plus ICCM
//   and DCCM word memories (mem_i). No I/O besides clock and reset.
//   Ports:
//     clk    in  core clock, all state updates on the rising edge
//     rst_n  in  asynchronous active-low reset
//   Sub-modules in this file:
//     rv32x_ram   word RAM, combinational read, byte-lane write
//     rv32x_mem   ICCM + DCCM with DCCM address decode
//     rv32x_core  single-cycle RV32I core (rf / pc / halted probed by name)
// ---------------------------------------------------------------------------

// Word RAM with combinational read and per-byte-lane synchronous write.
module rv32x_ram #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] ram_core [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) ram_core[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = ram_core[addr_i];
endmodule

// ICCM (read-only from the core) and DCCM with base/limit decode.
module rv32x_mem #(
  parameter int          ICCM_DEPTH = 1024,
  parameter int          DCCM_DEPTH = 1024,
  parameter logic [31:0] DCCM_BASE  = 32'h0001_0000
) (
  input logic            clk,
  rv32x_wrapper_if.slave bus
);
  localparam int          DAW     = $clog2(DCCM_DEPTH);
  localparam logic [29:0] DBASE_W = DCCM_BASE[31:2];

  // Offset from DCCM word 0; addresses below the base wrap to huge values,
  // so a single unsigned compare covers both ends of the window.
  logic [29:0] d_off;
  logic        d_hit;
  logic [31:0] d_rdata;

  assign d_off = bus.dmem_waddr - DBASE_W;
  assign d_hit = d_off < 30'(DCCM_DEPTH);

  if (1'b1) begin : iccm
    rv32x_ram #(.DEPTH(ICCM_DEPTH)) iccm_i0 (
      .clk     (clk),
      .be_i    (4'b0000),
      .addr_i  (bus.imem_idx),
      .wdata_i (32'h0),
      .rdata_o (bus.imem_rdata)
    );
  end

  if (1'b1) begin : dccm
    rv32x_ram #(.DEPTH(DCCM_DEPTH)) dccm_d0 (
      .clk     (clk),
      .be_i    (d_hit ? bus.dmem_be : 4'b0000),
      .addr_i  (d_off[DAW-1:0]),
      .wdata_i (bus.dmem_wdata),
      .rdata_o (d_rdata)
    );
  end

  assign bus.dmem_rdata = d_hit ? d_rdata : 32'h0;
endmodule

// Single-cycle RV32I core. rf, pc and halted keep these exact names so the
// bench can probe them hierarchically.
module rv32x_core #(
  parameter int          IAW      = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic             clk,
  input logic             rst_n,
  rv32x_wrapper_if.master bus
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f,
                         OP_JALR = 7'h67, OP_BR = 7'h63, OP_LD = 7'h03,
                         OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33,
                         OP_SYS = 7'h73;

  logic [31:0] rf [32];
  logic [31:0] pc;
  logic        halted;

  logic [31:0] pc_d, rd_wdata_d, st_wdata_d;
  logic        halted_d, rd_we_d, take;
  logic [3:0]  st_be_d;

  logic [31:0] instr, rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j, ea;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign instr   = bus.imem_rdata;
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rs1_val = rf[instr[19:15]];
  assign rs2_val = rf[instr[24:20]];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {instr[31:12], 12'h000};
  assign imm_j   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
  assign ea      = rs1_val + ((opcode == OP_ST) ? imm_s : imm_i);

  assign ld_byte = bus.dmem_rdata[{ea[1:0], 3'b000} +: 8];
  assign ld_half = ea[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];

  assign bus.imem_idx   = pc[IAW+1:2];
  assign bus.dmem_waddr = ea[31:2];
  assign bus.dmem_wdata = st_wdata_d;
  // A frozen core must not keep re-issuing a store.
  assign bus.dmem_be    = halted ? 4'b0000 : st_be_d;

  function automatic logic [31:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (fn)
      3'd0:    r = alt ? (a - b) : (a + b);
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'b0, $signed(a) < $signed(b)};
      3'd3:    r = {31'b0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb begin
    case (f3)
      3'd0:    take = (rs1_val == rs2_val);
      3'd1:    take = (rs1_val != rs2_val);
      3'd4:    take = ($signed(rs1_val) <  $signed(rs2_val));
      3'd5:    take = ($signed(rs1_val) >= $signed(rs2_val));
      3'd6:    take = (rs1_val <  rs2_val);
      3'd7:    take = (rs1_val >= rs2_val);
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    pc_d       = pc + 32'd4;
    halted_d   = 1'b0;
    rd_we_d    = 1'b0;
    rd_wdata_d = 32'h0;
    st_be_d    = 4'b0000;
    st_wdata_d = 32'h0;
    case (opcode)
      OP_LUI:   begin rd_we_d = 1'b1; rd_wdata_d = imm_u; end
      OP_AUIPC: begin rd_we_d = 1'b1; rd_wdata_d = pc + imm_u; end
      OP_JAL:   begin rd_we_d = 1'b1; rd_wdata_d = pc + 32'd4; pc_d = pc + imm_j; end
      OP_JALR: if (f3 == 3'd0) begin
        rd_we_d    = 1'b1;
        rd_wdata_d = pc + 32'd4;
        pc_d       = (rs1_val + imm_i) & 32'hFFFF_FFFE;
      end
      OP_BR: if (take) pc_d = pc + imm_b;
      OP_LD: begin
        rd_we_d = 1'b1;
        case (f3)
          3'd0:    rd_wdata_d = {{24{ld_byte[7]}}, ld_byte};
          3'd1:    rd_wdata_d = {{16{ld_half[15]}}, ld_half};
          3'd2:    rd_wdata_d = bus.dmem_rdata;
          3'd4:    rd_wdata_d = {24'h0, ld_byte};
          3'd5:    rd_wdata_d = {16'h0, ld_half};
          default: rd_we_d = 1'b0;
        endcase
      end
      OP_ST: begin
        case (f3)
          3'd0: begin st_be_d = 4'b0001 << ea[1:0]; st_wdata_d = {4{rs2_val[7:0]}}; end
          3'd1: begin st_be_d = ea[1] ? 4'b1100 : 4'b0011; st_wdata_d = {2{rs2_val[15:0]}}; end
          3'd2: begin st_be_d = 4'b1111; st_wdata_d = rs2_val; end
          default: st_be_d = 4'b0000;
        endcase
      end
      // Only funct3=5 uses instr[30] as the arithmetic-shift select; for the
      // other immediate ops that bit is part of the immediate.
      OP_IMM: if ((f3 == 3'd1) ? (f7 == 7'h00) :
                  (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1) begin
        rd_we_d    = 1'b1;
        rd_wdata_d = alu(f3, (f3 == 3'd5) && instr[30], rs1_val, imm_i);
      end
      OP_REG: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        rd_we_d    = 1'b1;
        rd_wdata_d = alu(f3, instr[30], rs1_val, rs2_val);
      end
      // ECALL / EBREAK freeze the core at the trapping instruction.
      OP_SYS: if (instr == 32'h0000_0073 || instr == 32'h0010_0073) begin
        halted_d = 1'b1;
        pc_d     = pc;
      end
      default: ;  // FENCE and unknown encodings retire as NOP
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (!halted) begin
      pc     <= pc_d;
      halted <= halted_d;
      if (rd_we_d && rd != 5'd0) rf[rd] <= rd_wdata_d;
    end
  end
endmodule

module rv32x_wrapper #(
  parameter int          ICCM_DEPTH = 1024,
  parameter int          DCCM_DEPTH = 1024,
  parameter logic [31:0] DCCM_BASE  = 32'h0001_0000,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst_n
);
  localparam int IAW = $clog2(ICCM_DEPTH);

  rv32x_wrapper_if #(.IAW(IAW)) bus ();

  rv32x_core #(.IAW(IAW), .RESET_PC(RESET_PC)) core_i (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  rv32x_mem #(
    .ICCM_DEPTH (ICCM_DEPTH),
    .DCCM_DEPTH (DCCM_DEPTH),
    .DCCM_BASE  (DCCM_BASE)
  ) mem_i (
    .clk (clk),
    .bus (bus.slave)
  );
endmodule

// File: tb/tb_rv32x_wrapper.sv
// ---------------------------------------------------------------------------
// tb_rv32x_wrapper
//   Directed programs plus random straight-line programs, executed on the
//   DUT and on an instruction-level reference model (byte-addressed data
//   memory) in lock step. pc is compared every cycle; registers and DCCM
//   contents are compared at the end of each program.
// ---------------------------------------------------------------------------
module tb_rv32x_wrapper;
  localparam logic [31:0] DBASE = 32'h0001_0000;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, IMM = 7'h13, LD = 7'h03,
                         JALR = 7'h67;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv32x_wrapper dut (.clk(clk), .rst_n(rst_n));

  int checks = 0;
  int errors = 0;
  int wp;

  // reference model state
  logic [31:0] m_imem [1024];
  logic [7:0]  m_dmem [4096];
  logic [31:0] m_x [32];
  logic [31:0] m_pc;
  logic        m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] i_t(input logic [6:0] op, input logic [2:0] f3,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f3,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] s_t(input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input logic [2:0] f3, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [31:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(input logic [6:0] op, input logic [4:0] rd,
      input logic [31:0] imm);
    return {imm[19:0], rd, op};
  endfunction
  function automatic logic [31:0] j_t(input logic [4:0] rd, input logic [31:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic in_dccm(input logic [31:0] a);
    return (a >= DBASE) && (a < DBASE + 32'd4096);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] ea, input int n);
    logic [31:0] base, v;
    base = ea & ~(32'(n) - 32'd1);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i);
      if (in_dccm(a)) v = v | (32'(m_dmem[12'(a - DBASE)]) << (8 * i));
    end
    return v;
  endfunction

  task automatic m_store(input logic [31:0] ea, input int n, input logic [31:0] v);
    logic [31:0] base;
    base = ea & ~(32'(n) - 32'd1);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i);
      if (in_dccm(a)) m_dmem[12'(a - DBASE)] = v[8*i +: 8];
    end
  endtask

  task automatic m_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, r, ea, nxt;
    logic [4:0] sh;
    logic [2:0] f3;
    logic [6:0] f7;
    logic wr, take, legal;
    if (m_halt) return;
    ins = m_imem[m_pc[11:2]];
    f3 = ins[14:12];
    f7 = ins[31:25];
    a  = m_x[ins[19:15]];
    b  = m_x[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iu = {ins[31:12], 12'h000};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt = m_pc + 32'd4;
    wr = 1'b0;
    r = 32'h0;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; r = iu; end
      7'h17: begin wr = 1'b1; r = m_pc + iu; end
      7'h6f: begin wr = 1'b1; r = m_pc + 32'd4; nxt = m_pc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; r = m_pc + 32'd4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: take = (a == b);
          3'd1: take = (a != b);
          3'd4: take = ($signed(a) < $signed(b));
          3'd5: take = !($signed(a) < $signed(b));
          3'd6: take = (a < b);
          3'd7: take = !(a < b);
          default: take = 1'b0;
        endcase
        if (take) nxt = m_pc + ib;
      end
      7'h03: begin
        ea = a + ii;
        wr = 1'b1;
        case (f3)
          3'd0: begin r = m_load(ea, 1); if (r[7])  r = r | 32'hFFFF_FF00; end
          3'd1: begin r = m_load(ea, 2); if (r[15]) r = r | 32'hFFFF_0000; end
          3'd2: r = m_load(ea, 4);
          3'd4: r = m_load(ea, 1);
          3'd5: r = m_load(ea, 2);
          default: wr = 1'b0;
        endcase
      end
      7'h23: begin
        ea = a + is;
        if (f3 == 3'd0) m_store(ea, 1, b);
        if (f3 == 3'd1) m_store(ea, 2, b);
        if (f3 == 3'd2) m_store(ea, 4, b);
      end
      7'h13, 7'h33: begin
        if (ins[6:0] == 7'h13) begin
          legal = (f3 == 3'd1) ? (f7 == 7'h00) : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
          b = ii;
        end else begin
          legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        end
        sh = b[4:0];
        case (f3)
          3'd0: r = (ins[6:0] == 7'h33 && f7 == 7'h20) ? a - b : a + b;
          3'd1: r = a << sh;
          3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: r = (a < b) ? 32'd1 : 32'd0;
          3'd4: r = a ^ b;
          3'd5: begin
            r = a >> sh;
            if (f7 == 7'h20 && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
          end
          3'd6: r = a | b;
          default: r = a & b;
        endcase
        wr = legal;
      end
      7'h73: if (ins == 32'h0000_0073 || ins == EBREAK) begin m_halt = 1'b1; nxt = m_pc; end
      default: ;
    endcase
    if (wr && ins[11:7] != 5'd0) m_x[ins[11:7]] = r;
    m_pc = nxt;
  endtask

  task automatic m_reset();
    m_pc = 32'h0;
    m_halt = 1'b0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
  endtask

  // ---------------- program / run helpers ----------------
  task automatic start_prog();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 1024; i++) begin
      dut.mem_i.iccm.iccm_i0.ram_core[i] = 32'h0;
      dut.mem_i.dccm.dccm_d0.ram_core[i] = 32'h0;
      m_imem[i] = 32'h0;
    end
    for (int i = 0; i < 4096; i++) m_dmem[i] = 8'h0;
    m_reset();
    wp = 0;
  endtask

  task automatic put(input logic [31:0] w);
    dut.mem_i.iccm.iccm_i0.ram_core[wp[9:0]] = w;
    m_imem[wp[9:0]] = w;
    wp++;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      m_step();
      check("pc_lockstep", dut.core_i.pc, m_pc);
    end
  endtask

  function automatic logic [31:0] dw(input int i);
    return dut.mem_i.dccm.dccm_d0.ram_core[i[9:0]];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [31:0] imm;
    logic [2:0] ld_f3 [5];
    logic [2:0] br_f3 [6];
    logic [31:0] w;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    rd  = 5'($urandom_range(1, 30));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    imm = $urandom;
    case ($urandom_range(0, 9))
      0: w = u_t(LUI, rd, imm);
      1: w = u_t(AUIPC, rd, imm);
      2: begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'd1) imm = {27'b0, imm[4:0]};
        else if (f3 == 3'd5) imm = {20'b0, 1'b0, imm[31], 5'b0, imm[4:0]};
        w = i_t(IMM, f3, rd, rs1, imm);
      end
      3, 4: begin
        f3 = 3'($urandom_range(0, 7));
        w = r_t(((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00, f3, rd, rs1, rs2);
      end
      5: w = i_t(LD, ld_f3[$urandom_range(0, 4)], rd, 5'd31, 32'($urandom_range(0, 1087)) - 32'd64);
      6: w = s_t(3'($urandom_range(0, 2)), 5'd31, rs2, 32'($urandom_range(0, 1087)) - 32'd64);
      7: w = b_t(br_f3[$urandom_range(0, 5)], rs1, rs2, 32'd8);
      8: w = j_t(rd, 32'd8);
      default: w = i_t(IMM, 3'd0, rd, rs1, imm);
    endcase
    return w;
  endfunction

  initial begin
    // ---- reset state ----
    start_prog();
    check("reset_pc", dut.core_i.pc, 32'h0);
    check("reset_halted", 32'(dut.core_i.halted), 32'h0);
    check("reset_x1", dut.core_i.rf[1], 32'h0);

    // ---- 1: ADDI / SUB ----
    start_prog();
    put(i_t(IMM, 3'd0, 5'd1, 5'd0, 32'd5));
    put(i_t(IMM, 3'd0, 5'd2, 5'd1, -32'sd7));
    put(r_t(7'h20, 3'd0, 5'd3, 5'd1, 5'd2));
    put(EBREAK);
    release_rst();
    run(3);
    check("t1_x1", dut.core_i.rf[1], 32'h5);
    check("t1_x2", dut.core_i.rf[2], 32'hFFFF_FFFE);
    check("t1_x3", dut.core_i.rf[3], 32'h7);

    // ---- 2: loads / stores, lanes, DCCM window edges ----
    start_prog();
    put(i_t(IMM, 3'd0, 5'd1, 5'd0, 32'hF0));
    put(u_t(LUI, 5'd5, 32'h10));
    put(s_t(3'd2, 5'd5, 5'd1, 32'd4));          // SW x1,4(x5)
    put(i_t(LD, 3'd0, 5'd6, 5'd5, 32'd4));      // LB
    put(i_t(LD, 3'd4, 5'd7, 5'd5, 32'd4));      // LBU
    put(i_t(IMM, 3'd0, 5'd8, 5'd0, -32'sd1));
    put(s_t(3'd2, 5'd5, 5'd8, 32'd8));          // SW x8,8(x5)
    put(s_t(3'd0, 5'd5, 5'd0, 32'd9));          // SB x0,9(x5)
    put(i_t(LD, 3'd2, 5'd9, 5'd5, 32'd8));      // LW
    put(i_t(LD, 3'd1, 5'd11, 5'd5, 32'd10));    // LH upper half
    put(i_t(LD, 3'd5, 5'd12, 5'd5, 32'd10));    // LHU upper half
    put(i_t(LD, 3'd1, 5'd15, 5'd5, 32'd8));     // LH lower half
    put(i_t(IMM, 3'd0, 5'd10, 5'd0, 32'd1));
    put(s_t(3'd2, 5'd0, 5'd1, 32'd0));          // miss below window
    put(i_t(LD, 3'd2, 5'd10, 5'd0, 32'd0));     // miss load -> 0
    put(u_t(LUI, 5'd13, 32'h11));
    put(s_t(3'd2, 5'd13, 5'd1, -32'sd4));       // last DCCM word
    put(s_t(3'd2, 5'd13, 5'd8, 32'd0));         // first address past window
    put(i_t(IMM, 3'd0, 5'd14, 5'd0, 32'd1));
    put(i_t(LD, 3'd2, 5'd14, 5'd13, 32'd0));
    put(i_t(LD, 3'd2, 5'd16, 5'd13, -32'sd4));
    put(EBREAK);
    release_rst();
    run(22);
    check("t2_dccm_w1", dw(1), 32'h0000_00F0);
    check("t2_lb", dut.core_i.rf[6], 32'hFFFF_FFF0);
    check("t2_lbu", dut.core_i.rf[7], 32'h0000_00F0);
    check("t2_dccm_w2_sb", dw(2), 32'hFFFF_00FF);
    check("t2_lw", dut.core_i.rf[9], 32'hFFFF_00FF);
    check("t2_lh_hi", dut.core_i.rf[11], 32'hFFFF_FFFF);
    check("t2_lhu_hi", dut.core_i.rf[12], 32'h0000_FFFF);
    check("t2_lh_lo", dut.core_i.rf[15], 32'h0000_00FF);
    check("t2_miss_load_lo", dut.core_i.rf[10], 32'h0);
    check("t2_miss_load_hi", dut.core_i.rf[14], 32'h0);
    check("t2_dccm_w0", dw(0), 32'h0);
    check("t2_dccm_last", dw(1023), 32'h0000_00F0);
    check("t2_lw_last", dut.core_i.rf[16], 32'h0000_00F0);
    check("t2_halted", 32'(dut.core_i.halted), 32'h1);

    // ---- 3: counted loop ----
    start_prog();
    put(i_t(IMM, 3'd0, 5'd2, 5'd0, 32'd10));
    put(i_t(IMM, 3'd0, 5'd1, 5'd1, 32'd1));
    put(b_t(3'd1, 5'd1, 5'd2, -32'sd4));
    put(EBREAK);
    release_rst();
    run(21);
    check("t3_x1", dut.core_i.rf[1], 32'd10);
    check("t3_pc_end", dut.core_i.pc, 32'h0000_000C);
    run(2);
    check("t3_pc_hold", dut.core_i.pc, 32'h0000_000C);

    // ---- 4: JAL / JALR, all-zero words run as NOP ----
    start_prog();
    wp = 8;
    put(j_t(5'd1, 32'd8));                      // 0x20
    put(EBREAK);                                // 0x24
    put(i_t(JALR, 3'd0, 5'd0, 5'd1, 32'd0));    // 0x28
    release_rst();
    run(9);
    check("t4_jal_link", dut.core_i.rf[1], 32'h0000_0024);
    check("t4_jal_pc", dut.core_i.pc, 32'h0000_0028);
    run(1);
    check("t4_jalr_pc", dut.core_i.pc, 32'h0000_0024);
    run(1);
    check("t4_halt_pc", dut.core_i.pc, 32'h0000_0024);

    // ---- 5: shifts and compares ----
    start_prog();
    put(u_t(LUI, 5'd1, 32'h80000));
    put(i_t(IMM, 3'd5, 5'd2, 5'd1, 32'h404));   // SRAI x2,x1,4
    put(i_t(IMM, 3'd5, 5'd3, 5'd1, 32'h004));   // SRLI x3,x1,4
    put(i_t(IMM, 3'd0, 5'd4, 5'd0, 32'd1));
    put(i_t(IMM, 3'd0, 5'd5, 5'd0, -32'sd1));
    put(r_t(7'h00, 3'd3, 5'd6, 5'd4, 5'd5));    // SLTU
    put(r_t(7'h00, 3'd2, 5'd7, 5'd4, 5'd5));    // SLT
    put(i_t(IMM, 3'd3, 5'd8, 5'd4, -32'sd1));   // SLTIU
    put(r_t(7'h00, 3'd0, 5'd9, 5'd5, 5'd4));    // ADD wraps
    put(EBREAK);
    release_rst();
    run(10);
    check("t5_srai", dut.core_i.rf[2], 32'hF800_0000);
    check("t5_srli", dut.core_i.rf[3], 32'h0800_0000);
    check("t5_sltu", dut.core_i.rf[6], 32'h1);
    check("t5_slt", dut.core_i.rf[7], 32'h0);
    check("t5_sltiu", dut.core_i.rf[8], 32'h1);
    check("t5_add_wrap", dut.core_i.rf[9], 32'h0);

    // ---- 6: EBREAK freeze, asynchronous reset mid-run ----
    start_prog();
    put(i_t(IMM, 3'd0, 5'd3, 5'd0, 32'd7));
    wp = 16;
    put(EBREAK);                                // 0x40
    put(i_t(IMM, 3'd0, 5'd3, 5'd3, 32'd1));
    release_rst();
    run(16);
    check("t6_pc_at_ebreak", dut.core_i.pc, 32'h0000_0040);
    run(100);
    check("t6_pc_frozen", dut.core_i.pc, 32'h0000_0040);
    check("t6_halted", 32'(dut.core_i.halted), 32'h1);
    check("t6_x3_frozen", dut.core_i.rf[3], 32'h7);
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    check("t6_rst_pc", dut.core_i.pc, 32'h0);
    check("t6_rst_halted", 32'(dut.core_i.halted), 32'h0);
    check("t6_rst_x3", dut.core_i.rf[3], 32'h0);
    release_rst();
    run(1);
    check("t6_restart_x3", dut.core_i.rf[3], 32'h7);
    check("t6_restart_pc", dut.core_i.pc, 32'h0000_0004);

    // ---- random straight-line programs against the model ----
    for (int p = 0; p < 3; p++) begin
      int cyc;
      start_prog();
      put(u_t(LUI, 5'd31, 32'h10));
      for (int k = 0; k < 150; k++) put(rand_instr());
      put(EBREAK);
      put(EBREAK);
      release_rst();
      cyc = 0;
      while (!m_halt && cyc < 600) begin
        run(1);
        cyc++;
      end
      run(2);
      check("rand_halted", 32'(dut.core_i.halted), 32'h1);
      for (int r = 0; r < 32; r++) check($sformatf("rand_x%0d", r), dut.core_i.rf[r], m_x[r]);
      for (int i = 0; i < 264; i++)
        check($sformatf("rand_dccm%0d", i), dw(i),
              {m_dmem[4*i+3], m_dmem[4*i+2], m_dmem[4*i+1], m_dmem[4*i]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
